// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART serialiser (start, DBIT data LSB-first, optional parity, stop); in: clk, rst, s_tick enable, tx_start/din taken when tx_ready; out: tx_ready, tx_done_tick pulse, registered tx line
module uart_tx_frame #(
  parameter int DBIT = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK = 16,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_ready,
  output logic            tx_done_tick,
  output logic            tx
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [4:0] tick_cnt, tick_n;
  logic [3:0] bit_cnt, bit_n;
  logic [DBIT-1:0] shreg, sh_n;
  logic par, par_n, tx_n, done_n, last;
  assign tx_ready = state == IDLE;
  assign last = s_tick && tick_cnt == (state == STOP ? 5'(SB_TICK - 1) : 5'(OVERSAMPLE - 1));
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tick_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      tx <= 1'b1;
      tx_done_tick <= 1'b0;
    end else begin
      state <= state_n;
      tick_cnt <= tick_n;
      bit_cnt <= bit_n;
      shreg <= sh_n;
      par <= par_n;
      tx <= tx_n;
      tx_done_tick <= done_n;
    end
  always_comb begin
    state_n = state;
    tick_n = tick_cnt;
    bit_n = bit_cnt;
    sh_n = shreg;
    par_n = par;
    tx_n = tx;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (tx_start) begin
        state_n = START;
        tick_n = '0;
        bit_n = '0;
        sh_n = din;
        par_n = ^din ^ (PARITY_ODD != 0);
        tx_n = 1'b0;
      end
    end else if (s_tick) begin
      tick_n = last ? 5'd0 : tick_cnt + 5'd1;
      if (last)
        case (state)
          START: begin
            state_n = DATA;
            tx_n = shreg[0];
          end
          DATA: begin
            sh_n = shreg >> 1;
            bit_n = bit_cnt + 4'd1;
            state_n = bit_cnt != 4'(DBIT - 1) ? DATA : PARITY_EN != 0 ? PARITY : STOP;
            tx_n = bit_cnt != 4'(DBIT - 1) ? shreg[1] : PARITY_EN != 0 ? par : 1'b1;
          end
          PARITY: begin
            state_n = STOP;
            tx_n = 1'b1;
          end
          default: begin
            state_n = IDLE;
            tx_n = 1'b1;
            done_n = 1'b1;
          end
        endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: random-stimulus bench running five frame configurations against a tick-counting frame model
module tb_uart_tx_frame;
  logic clk = 1'b0, rst = 1'b1, s_tick = 1'b0, fin = 1'b0;
  int cyc = 0, n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  localparam int DB [5] = '{8, 8, 8, 7, 5};
  localparam int OS [5] = '{16, 16, 8, 16, 32};
  localparam int SB [5] = '{16, 16, 12, 32, 32};
  localparam int PE [5] = '{0, 1, 1, 0, 1};
  localparam int PO [5] = '{0, 0, 1, 0, 1};
  localparam logic [8:0] FX [5] = '{9'h0A5, 9'h007, 9'h007, 9'h041, 9'h015};
  task automatic chk(input string tag, input int id, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL c%0d %s: got %0d expected %0d at cycle %0d", id, tag, got, exp, cyc);
  endtask
  for (genvar g = 0; g < 5; g++) begin : cfg
    localparam int D = DB[g], O = OS[g], S = SB[g], P = PE[g], Q = PO[g];
    localparam int NB = 1 + D + P, T = NB * O + S;
    localparam logic [8:0] F = FX[g];
    logic start = 1'b0, tx, rdy, dn, busy = 1'b0, first = 1'b1;
    logic [D-1:0] din = '0;
    logic [10:0] bits = '0;
    int k = 0, frames = 0;
    uart_tx_frame #(.DBIT(D), .OVERSAMPLE(O), .SB_TICK(S), .PARITY_EN(P), .PARITY_ODD(Q)) dut (
      .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(start), .din(din),
      .tx_ready(rdy), .tx_done_tick(dn), .tx(tx)
    );
    // k = s_ticks seen since accept; frame complete when k reaches T
    always @(posedge clk)
      if (rst) begin
        busy = 1'b0;
        k = 0;
      end else if (!busy || k == T) begin
        busy = start;
        k = 0;
        if (start) begin
          first = 1'b0;
          bits = '0;
          for (int i = 0; i < D; i++) bits[1+i] = din[i];
          if (P != 0) bits[1+D] = ^din ^ (Q != 0);
        end
      end else if (s_tick) begin
        k++;
        if (k == T) frames++;
      end
    always @(negedge clk) begin
      if (!fin) begin
        chk("tx", g, int'(tx), int'(!busy || k >= NB * O ? 1'b1 : bits[k/O]));
        chk("tx_ready", g, int'(rdy), int'(!busy || k == T));
        chk("tx_done_tick", g, int'(dn), int'(busy && k == T));
      end
      start = (cyc / 3000) % 2 == 1 || $urandom_range(0, 15) == 0;
      din = first ? F[D-1:0] : D'($urandom);
    end
    initial begin
      wait (fin);
      chk("frames>=3", g, int'(frames >= 3), 1);
    end
  end
  initial begin
    repeat (20000) begin
      @(negedge clk);
      rst = cyc < 2 || cyc == 7001;
      s_tick = cyc < 10000 ? cyc % 4 == 0 : $urandom_range(0, 2) == 0;
      cyc++;
    end
    @(negedge clk);
    fin = 1'b1;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
